swin_debounce: RTL and testbench

SWIN_DEBOUNCE -- requirements
Module: swin_debounce

---
 rtl/swin_debounce.sv | 146 ++++++++++++++
 tb/tb_swin_debounce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/swin_debounce.sv
// Debounced switch bank with a STATE/EDGE/MASK register window on the iomem bus.
// Define SWIN_IRQ_EN to build the EDGE/MASK registers and the irq output.
module swin_debounce_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CW              = 17
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic chg
);
  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // stable flips on the edge where the counter already sits at the limit
  assign chg = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (chg) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module swin_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter logic [7:0]  BASE_OFF        = 8'h10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  output logic             irq
);
  localparam int unsigned CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [7:0]  OFF_STATE = BASE_OFF;
  localparam logic [7:0]  OFF_EDGE  = BASE_OFF + 8'd4;
  localparam logic [7:0]  OFF_MASK  = BASE_OFF + 8'd8;

  typedef struct packed {
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iomem_req_t;

  iomem_req_t       req;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] edge_rd, mask_rd;
  logic             sel, is_wr, sel_edge, sel_mask;
  logic [31:0]      rd_val;

  assign req = '{valid: iomem_valid, wstrb: iomem_wstrb, addr: iomem_addr, wdata: iomem_wdata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    swin_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .chg    (chg[i])
    );
  end

  // ready gates selection so each request gets exactly one single-cycle ack
  assign sel      = req.valid && !iomem_ready && (req.addr[31:24] == 8'h03) &&
                    (req.addr[7:0] == OFF_STATE || req.addr[7:0] == OFF_EDGE ||
                     req.addr[7:0] == OFF_MASK);
  assign is_wr    = |req.wstrb;
  assign sel_edge = sel && (req.addr[7:0] == OFF_EDGE);
  assign sel_mask = sel && (req.addr[7:0] == OFF_MASK);

  always_comb begin
    rd_val = 32'h0;
    if (req.addr[7:0] == OFF_STATE)     rd_val = 32'(sw_stable);
    else if (req.addr[7:0] == OFF_EDGE) rd_val = 32'(edge_rd);
    else if (req.addr[7:0] == OFF_MASK) rd_val = 32'(mask_rd);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_val;
    end
  end

`ifdef SWIN_IRQ_EN
  logic [WIDTH-1:0] edge_q, mask_q, clr, mask_nxt;

  always_comb begin
    clr      = '0;
    mask_nxt = mask_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < 8 && sel_edge && is_wr && req.wstrb[0]) clr[i] = req.wdata[i];
      if (sel_mask && req.wstrb[i >> 3]) mask_nxt[i] = req.wdata[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edge_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clr) | chg;
      mask_q <= mask_nxt;
      irq    <= |(edge_q & mask_q);
    end
  end

  assign edge_rd = edge_q;
  assign mask_rd = mask_q;
`else
  assign edge_rd = '0;
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  logic unused;
  assign unused = &{1'b0, req.addr[23:8], req.wdata, req.wstrb, chg, is_wr, sel_edge, sel_mask};
endmodule

// File: tb/tb_swin_debounce.sv
// Directed bench for swin_debounce (WIDTH=4, DEBOUNCE_CYCLES=4); tracks SWIN_IRQ_EN.
module tb_swin_debounce;
  localparam int W = 4;
  localparam int D = 4;
  localparam logic [31:0] A_STATE = 32'h0300_0010;
  localparam logic [31:0] A_EDGE  = 32'h0300_0014;
  localparam logic [31:0] A_MASK  = 32'h0300_0018;
`ifdef SWIN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  sw_raw = '0;
  logic [W-1:0]  sw_stable;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb = '0;
  logic [31:0]   iomem_addr = '0;
  logic [31:0]   iomem_wdata = '0;
  logic [31:0]   iomem_rdata;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  swin_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .BASE_OFF(8'h10)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw_raw      (sw_raw),
    .sw_stable   (sw_stable),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge where ready was seen (or after 4 cycles).
  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output bit ok);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (iomem_ready) begin ok = 1'b1; rd = iomem_rdata; end
    end
    iomem_valid = 1'b0; iomem_wstrb = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({sw_stable, iomem_ready, irq} !== '0 || iomem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %b/%b/%b/%h expected 0", sw_stable, iomem_ready, irq, iomem_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b0 || iomem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got %b/%b expected 0/0", sw_stable, iomem_ready);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] rd; bit ok;
    sw_raw = 4'b0101;
    repeat (5) @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b0000) begin n_fail++; $display("FAIL stable_edge5: got %b expected 0000", sw_stable); end
    @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b0101) begin n_fail++; $display("FAIL stable_edge6: got %b expected 0101", sw_stable); end
    bus_xfer(A_STATE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h5) begin n_fail++; $display("FAIL state_read: got %0b/%h expected 1/00000005", ok, rd); end
    bus_xfer(A_STATE, 4'hF, 32'hFFFF_FFFF, rd, ok);
    bus_xfer(A_STATE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h5) begin n_fail++; $display("FAIL state_ro: got %h expected 00000005", rd); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== (IRQ_EN ? 32'h5 : 32'h0)) begin n_fail++; $display("FAIL edge_after_change: got %h expected %h", rd, IRQ_EN ? 32'h5 : 32'h0); end
    bus_xfer(A_EDGE, 4'h1, 32'hF, rd, ok);
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL edge_cleared: got %h expected 00000000", rd); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd; bit ok; bit moved = 1'b0;
    sw_raw = 4'b0111;
    repeat (3) begin @(negedge clk); if (sw_stable[1]) moved = 1'b1; end
    sw_raw = 4'b0101;
    repeat (10) begin @(negedge clk); if (sw_stable[1]) moved = 1'b1; end
    n_tests++;
    if (moved || sw_stable !== 4'b0101) begin n_fail++; $display("FAIL glitch_stable: got moved=%0b %b expected 0 0101", moved, sw_stable); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %h expected 00000000", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; bit ok;
    bus_xfer(A_MASK, 4'hF, 32'h1, rd, ok);
    bus_xfer(A_MASK, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== (IRQ_EN ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL mask_rw: got %h expected %h", rd, IRQ_EN ? 32'h1 : 32'h0); end
    bus_xfer(A_MASK, 4'hE, 32'hFFFF_FFF0, rd, ok);
    bus_xfer(A_MASK, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== (IRQ_EN ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL mask_strb: got %h expected %h", rd, IRQ_EN ? 32'h1 : 32'h0); end
    bus_xfer(A_MASK, 4'h1, 32'hFFFF_FFFF, rd, ok);
    bus_xfer(A_MASK, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== (IRQ_EN ? 32'hF : 32'h0)) begin n_fail++; $display("FAIL mask_upper_zero: got %h expected %h", rd, IRQ_EN ? 32'hF : 32'h0); end
    bus_xfer(A_MASK, 4'h1, 32'h1, rd, ok);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq); end
    sw_raw = 4'b0100;
    repeat (8) @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b0100) begin n_fail++; $display("FAIL toggle_stable: got %b expected 0100", sw_stable); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== (IRQ_EN ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL edge_bit0: got %h expected %h", rd, IRQ_EN ? 32'h1 : 32'h0); end
    n_tests++;
    if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_set: got %b expected %b", irq, IRQ_EN); end
    bus_xfer(A_EDGE, 4'h1, 32'h1, rd, ok);
    n_tests++;
    if (!ok || irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_at_ready: got %0b/%b expected 1/%b", ok, irq, IRQ_EN); end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd; bit ok;
    sw_raw = 4'b0000;
    repeat (5) @(negedge clk);
    bus_xfer(A_EDGE, 4'h1, 32'h4, rd, ok);   // selection edge is the 6th edge
    n_tests++;
    if (!ok || sw_stable !== 4'b0000) begin n_fail++; $display("FAIL same_edge_stable: got %0b/%b expected 1/0000", ok, sw_stable); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== (IRQ_EN ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL set_wins: got %h expected %h", rd, IRQ_EN ? 32'h4 : 32'h0); end
    bus_xfer(A_EDGE, 4'h1, 32'h4, rd, ok);
    n_tests++;
    if (rd !== (IRQ_EN ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL edge_preclear: got %h expected %h", rd, IRQ_EN ? 32'h4 : 32'h0); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_w1c: got %h expected 00000000", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; bit ok;
    bus_xfer(32'h0300_0000, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (ok) begin n_fail++; $display("FAIL unmapped_off: got ready=1 expected 0"); end
    bus_xfer(32'h0400_0010, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (ok) begin n_fail++; $display("FAIL unmapped_page: got ready=1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit ok; int pulses = 0; bit dbl = 1'b0; logic prev = 1'b0;
    bus_xfer(A_STATE, 4'h0, 32'h0, rd, ok);
    repeat (4) begin @(negedge clk); if (iomem_ready) pulses++; end
    n_tests++;
    if (!ok || pulses != 0) begin n_fail++; $display("FAIL single_pulse: got ok=%0b extra=%0d expected 1/0", ok, pulses); end
    iomem_valid = 1'b1; iomem_addr = A_STATE; iomem_wstrb = 4'h0;
    repeat (6) begin
      @(negedge clk);
      if (iomem_ready) pulses++;
      if (iomem_ready && prev) dbl = 1'b1;
      prev = iomem_ready;
    end
    iomem_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pulses != 3 || dbl) begin n_fail++; $display("FAIL held_valid: got %0d pulses dbl=%0b expected 3/0", pulses, dbl); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit ok; int pulses = 0;
    sw_raw = 4'b0001;
    repeat (8) @(negedge clk);
    bus_xfer(A_STATE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== 32'h1 || irq !== IRQ_EN) begin n_fail++; $display("FAIL pre_reset: got %h/%b expected 00000001/%b", rd, irq, IRQ_EN); end
    sw_raw = 4'b1011;
    repeat (3) @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = A_STATE; iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({sw_stable, iomem_ready, irq} !== '0 || iomem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_async: got %b/%b/%b/%h expected 0", sw_stable, iomem_ready, irq, iomem_rdata);
    end
    repeat (3) begin @(negedge clk); if (iomem_ready) pulses++; end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_abort: got %0d pulses expected 0", pulses); end
    iomem_valid = 1'b0;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b0000) begin n_fail++; $display("FAIL post_reset_edge5: got %b expected 0000", sw_stable); end
    @(negedge clk);
    n_tests++;
    if (sw_stable !== 4'b1011) begin n_fail++; $display("FAIL post_reset_edge6: got %b expected 1011", sw_stable); end
    bus_xfer(A_EDGE, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (!ok || rd !== (IRQ_EN ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL post_reset_edge: got %h expected %h", rd, IRQ_EN ? 32'hB : 32'h0); end
    bus_xfer(A_MASK, 4'h0, 32'h0, rd, ok);
    n_tests++;
    if (rd !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_mask: got %h/%b expected 00000000/0", rd, irq); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_debounce();
    test_glitch();
    test_irq();
    test_set_wins();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
